// File: rtl/button_pkg.sv
// Shared types and parameter-to-cycle helpers for the button press detector.
package button_pkg;

   // Press-tracking states: released, held below the long threshold, held past it.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } state_e;

   // Milliseconds to clock cycles at the given clock frequency.
   function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
      longint unsigned prod;
      prod = (64'(freq) * 64'(ms)) / 64'd1000;
      return 32'(prod);
   endfunction

   // Seconds to clock cycles at the given clock frequency.
   function automatic int unsigned s_to_cycles(input int unsigned freq, input int unsigned secs);
      longint unsigned prod;
      prod = 64'(freq) * 64'(secs);
      return 32'(prod);
   endfunction

   // Bits needed to hold the value n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, polarity normalisation and debounce counter.
module button_debounce #(
   parameter int unsigned DB         = 5,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic level_o,
   output logic toggle_c
);
   import button_pkg::*;

   localparam int unsigned CW       = cnt_width(DB);
   localparam logic        IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

   logic          s1_q, s2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed;

   assign pressed  = ACTIVE_LOW ? ~s2_q : s2_q;
   assign level_o  = level_q;
   assign toggle_c = level_d ^ level_q;

   // Count consecutive disagreeing cycles; flip the level on the DB-th one.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (pressed != level_q) begin
         if (cnt_q == CW'(DB - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Synchroniser resets to the released pin value so reset never looks like a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q    <= IDLE_LVL;
         s2_q    <= IDLE_LVL;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/button_press.sv
// Debounced button with press/release edges and short/long press classification.
module button_press #(
   parameter int unsigned FREQ        = 25000000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_SECS   = 1,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic short_o,
   output logic long_o
);
   import button_pkg::*;

   localparam int unsigned DB     = ms_to_cycles(FREQ, DEBOUNCE_MS);
   localparam int unsigned LH     = s_to_cycles(FREQ, LONG_SECS);
   localparam int unsigned HOLD_W = cnt_width(LH);

   logic              level;
   logic              toggle;
   logic              rise_ev, fall_ev;
   state_e            state_q;
   logic [HOLD_W-1:0] hold_q;
   logic              press_q, release_q, short_q, long_q;

   button_debounce #(
      .DB         (DB),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_debounce (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .raw_i    (btn_i),
      .level_o  (level),
      .toggle_c (toggle)
   );

   // Level flips at this edge: pulses land in the first cycle of the new level.
   assign rise_ev = toggle & ~level;
   assign fall_ev = toggle &  level;

   assign level_o   = level;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign short_o   = short_q;
   assign long_o    = long_q;

   // Press classifier; hold_q reads 0 in the press_o cycle and LH-1 in the long_o cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         press_q   <= rise_ev;
         release_q <= fall_ev;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rise_ev) begin
                  state_q <= ST_HELD;
                  hold_q  <= '0;
               end
            end
            ST_HELD: begin
               if (fall_ev) begin
                  short_q <= 1'b1;
                  state_q <= ST_IDLE;
                  hold_q  <= '0;
               end else if (hold_q == HOLD_W'(LH - 2)) begin
                  long_q  <= 1'b1;
                  state_q <= ST_LONG;
                  hold_q  <= hold_q + HOLD_W'(1);
               end else begin
                  hold_q  <= hold_q + HOLD_W'(1);
               end
            end
            ST_LONG: begin
               if (fall_ev) begin
                  state_q <= ST_IDLE;
                  hold_q  <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               hold_q  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_press.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor retires them.
module tb_button_press;

   localparam int LAT = 7;      // DB + 2 edges from pin change to level change
   localparam int LH  = 1000;

   typedef enum int {EV_PRESS, EV_RELEASE, EV_SHORT, EV_LONG} ev_e;
   typedef struct {
      ev_e kind;
      int  cyc;
   } exp_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic btn    = 1'b1;
   logic level, press, rel, shrt, lng;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   button_press #(
      .FREQ        (1000),
      .DEBOUNCE_MS (5),
      .LONG_SECS   (1),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .btn_i     (btn),
      .level_o   (level),
      .press_o   (press),
      .release_o (rel),
      .short_o   (shrt),
      .long_o    (lng)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Retire one pulse against the head of the scoreboard.
   task automatic mon_one(input ev_e k);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_pulse: got %s at cycle %0d, required no pulse", k.name(), cyc);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                     k.name(), cyc, e.kind.name(), e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (press) mon_one(EV_PRESS);
      if (rel)   mon_one(EV_RELEASE);
      if (shrt)  mon_one(EV_SHORT);
      if (lng)   mon_one(EV_LONG);
   end

   task automatic push(input ev_e k, input int c);
      exp_t e;
      e.kind = k;
      e.cyc  = c;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_level(input logic exp, input string name);
      checks++;
      if (level !== exp) begin
         errors++;
         $display("FAIL %s: level_o=%b at cycle %0d, required %b", name, level, cyc, exp);
      end
   endtask

   task automatic check_quiet(input string name);
      logic [4:0] v;
      v = {level, press, rel, shrt, lng};
      checks++;
      if (v !== 5'b0) begin
         errors++;
         $display("FAIL %s: outputs {lvl,prs,rel,sht,lng}=%b, required 00000", name, v);
      end
   endtask

   // Bounded wait for every queued pulse to be retired.
   task automatic drain(input string name, input int budget);
      int b;
      b = budget;
      while (sb_q.size() != 0 && b > 0) begin
         step(1);
         b--;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected pulses still pending, first %s at cycle %0d, required 0 pending",
                  name, sb_q.size(), sb_q[0].kind.name(), sb_q[0].cyc);
         sb_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation still running at %0t, required completion", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n, m;

      // Reset with button released, then 100 idle cycles.
      rst_n = 1'b0;
      btn   = 1'b1;
      step(3);
      check_quiet("in_reset");
      rst_n = 1'b1;
      step(100);
      check_quiet("idle_100");

      // Bouncing press: toggle every 2 cycles, then settle pressed.
      for (int i = 0; i < 10; i++) begin
         btn = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(2);
      end
      btn = 1'b0;
      n = cyc;
      push(EV_PRESS, n + LAT);
      step(LAT - 1);
      check_level(1'b0, "bounce_before_rise");
      step(1);
      check_level(1'b1, "bounce_rise");
      step(40);
      btn = 1'b1;
      m = cyc;
      push(EV_RELEASE, m + LAT);
      push(EV_SHORT,   m + LAT);
      drain("bounce_release", 30);
      check_level(1'b0, "bounce_released");

      // Four-cycle glitch must be ignored.
      step(10);
      btn = 1'b0;
      step(4);
      btn = 1'b1;
      step(20);
      check_quiet("glitch");

      // Short press of 200 cycles.
      btn = 1'b0;
      n = cyc;
      push(EV_PRESS, n + LAT);
      step(100);
      check_level(1'b1, "short_held");
      step(100);
      btn = 1'b1;
      m = cyc;
      push(EV_RELEASE, m + LAT);
      push(EV_SHORT,   m + LAT);
      drain("short_press", 20);
      step(10);

      // Long press of 1500 cycles.
      btn = 1'b0;
      n = cyc;
      push(EV_PRESS, n + LAT);
      push(EV_LONG,  n + LAT + LH - 1);
      step(1500);
      btn = 1'b1;
      m = cyc;
      push(EV_RELEASE, m + LAT);
      drain("long_press", 20);
      step(10);

      // Release lands exactly on the threshold cycle: short wins.
      btn = 1'b0;
      n = cyc;
      push(EV_PRESS, n + LAT);
      step(LH - 1);
      btn = 1'b1;
      m = cyc;
      push(EV_RELEASE, n + LAT + LH - 1);
      push(EV_SHORT,   m + LAT);
      drain("threshold_short", 20);
      step(10);

      // Release one cycle past the threshold: long, then plain release.
      btn = 1'b0;
      n = cyc;
      push(EV_PRESS, n + LAT);
      push(EV_LONG,  n + LAT + LH - 1);
      step(LH);
      btn = 1'b1;
      m = cyc;
      push(EV_RELEASE, m + LAT);
      drain("threshold_long", 20);
      step(10);

      // Reset during LONG with the button still held.
      btn = 1'b0;
      n = cyc;
      push(EV_PRESS, n + LAT);
      push(EV_LONG,  n + LAT + LH - 1);
      step(1100);
      drain("pre_reset_long", 1);
      rst_n = 1'b0;
      step(3);
      check_quiet("reset_in_long");
      rst_n = 1'b1;
      n = cyc;
      push(EV_PRESS, n + LAT);
      push(EV_LONG,  n + LAT + LH - 1);
      step(LAT - 1);
      check_level(1'b0, "rearm_before_rise");
      step(1);
      check_level(1'b1, "rearm_rise");
      step(1093);
      btn = 1'b1;
      m = cyc;
      push(EV_RELEASE, m + LAT);
      drain("rearm_long", 20);
      step(10);
      check_quiet("final_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
